// File: rtl/sys_cmd_rx_ctrl_if.sv
// Receive-side command bus between the UART byte stream and the system controller.
// The master drives received bytes; the slave (controller) drives register-file, ALU and status outputs.
interface sys_cmd_rx_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 4,
    parameter int FUN_W = 4
);
    logic [WIDTH-1:0] Rx_P_Data;
    logic             RxValid;
    logic             ALU_EN;
    logic [FUN_W-1:0] ALU_FUN;
    logic [AW-1:0]    Reg_File_Address;
    logic             WrEN;
    logic             RdEN;
    logic [WIDTH-1:0] WrData;
    logic             CLK_GATE_EN;
    logic             Frame_Err;
    logic             Busy;

    modport master (
        output Rx_P_Data, RxValid,
        input  ALU_EN, ALU_FUN, Reg_File_Address, WrEN, RdEN, WrData,
               CLK_GATE_EN, Frame_Err, Busy
    );

    modport slave (
        input  Rx_P_Data, RxValid,
        output ALU_EN, ALU_FUN, Reg_File_Address, WrEN, RdEN, WrData,
               CLK_GATE_EN, Frame_Err, Busy
    );
endinterface

// File: rtl/sys_cmd_rx_ctrl.sv
// Byte-framed command decoder: turns received bytes into register-file writes/reads,
// burst writes and ALU launches, with address/length checking and an inter-byte timeout.
module sys_cmd_rx_ctrl #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int FUN_W     = 4,
    parameter int OPA_ADDR  = 0,
    parameter int OPB_ADDR  = 1,
    parameter int MAX_BURST = 8,
    parameter int TIMEOUT   = 1024
) (
    input logic               CLK,
    input logic               Reset,
    sys_cmd_rx_ctrl_if.slave  bus
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = $clog2(MAX_BURST + 1);
    localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    localparam logic [WIDTH-1:0] OP_WR  = WIDTH'(8'hAA);
    localparam logic [WIDTH-1:0] OP_RD  = WIDTH'(8'hBB);
    localparam logic [WIDTH-1:0] OP_ALU = WIDTH'(8'hCC);
    localparam logic [WIDTH-1:0] OP_ALN = WIDTH'(8'hDD);
    localparam logic [WIDTH-1:0] OP_BST = WIDTH'(8'hEE);

    typedef enum logic [3:0] {
        IDLE, WADDR, WDATA, RADDR, BADDR, BCNT, BDATA, OPA, OPB, FUN
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [TW-1:0]    tcnt;
    logic [AW-1:0]    baddr_p1;
    logic [CW-1:0]    bcnt_p1;

    logic             wr_en_p1, rd_en_p1, alu_en_p1, err_p1, cge_p1;
    logic [AW-1:0]    addr_p1;
    logic [WIDTH-1:0] data_p1;
    logic [FUN_W-1:0] fun_p1;

    logic             wr_en_p0, rd_en_p0, alu_en_p0, err_p0, cge_p0;
    logic [AW-1:0]    addr_p0;
    logic [WIDTH-1:0] data_p0;
    logic [FUN_W-1:0] fun_p0;
    logic [AW-1:0]    baddr_p0;
    logic [CW-1:0]    bcnt_p0;

    logic             vld_p0;
    logic [WIDTH-1:0] byte_p0;
    logic             addr_ok_p0;
    logic             len_ok_p0;
    logic             tmo_p0;

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] a);
        return (a == AW'(DEPTH - 1)) ? '0 : a + 1'b1;
    endfunction

    // ---- stage p0: byte qualification ----
    assign vld_p0     = bus.RxValid;
    assign byte_p0    = bus.Rx_P_Data;
    assign addr_ok_p0 = (byte_p0 < WIDTH'(DEPTH));
    assign len_ok_p0  = (byte_p0 != '0) && (byte_p0 <= WIDTH'(MAX_BURST));
    // A byte arriving on the expiry cycle wins over the timeout.
    assign tmo_p0     = (TIMEOUT != 0) && (state != IDLE) && !vld_p0 && (tcnt == TW'(TLIM));

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset || (state == IDLE) || vld_p0) begin
            tcnt <= '0;
        end else if (tcnt != TW'(TLIM)) begin
            tcnt <= tcnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (tmo_p0) begin
            state_nxt = IDLE;
        end else if (vld_p0) begin
            case (state)
                IDLE: begin
                    case (byte_p0)
                        OP_WR:   state_nxt = WADDR;
                        OP_RD:   state_nxt = RADDR;
                        OP_ALU:  state_nxt = OPA;
                        OP_ALN:  state_nxt = FUN;
                        OP_BST:  state_nxt = BADDR;
                        default: state_nxt = IDLE;
                    endcase
                end
                WADDR:   state_nxt = addr_ok_p0 ? WDATA : IDLE;
                WDATA:   state_nxt = IDLE;
                RADDR:   state_nxt = IDLE;
                BADDR:   state_nxt = addr_ok_p0 ? BCNT : IDLE;
                BCNT:    state_nxt = len_ok_p0 ? BDATA : IDLE;
                BDATA:   state_nxt = (bcnt_p1 == CW'(1)) ? IDLE : BDATA;
                OPA:     state_nxt = OPB;
                OPB:     state_nxt = FUN;
                FUN:     state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        wr_en_p0  = 1'b0;
        rd_en_p0  = 1'b0;
        alu_en_p0 = 1'b0;
        err_p0    = 1'b0;
        addr_p0   = addr_p1;
        data_p0   = data_p1;
        fun_p0    = fun_p1;
        baddr_p0  = baddr_p1;
        bcnt_p0   = bcnt_p1;
        if (tmo_p0) begin
            err_p0 = 1'b1;
        end else if (vld_p0) begin
            case (state)
                IDLE: begin
                    if (!(byte_p0 inside {OP_WR, OP_RD, OP_ALU, OP_ALN, OP_BST})) begin
                        err_p0 = 1'b1;
                    end
                end
                WADDR, BADDR: begin
                    if (addr_ok_p0) begin
                        baddr_p0 = byte_p0[AW-1:0];
                    end else begin
                        err_p0 = 1'b1;
                    end
                end
                WDATA: begin
                    wr_en_p0 = 1'b1;
                    addr_p0  = baddr_p1;
                    data_p0  = byte_p0;
                end
                RADDR: begin
                    if (addr_ok_p0) begin
                        rd_en_p0 = 1'b1;
                        addr_p0  = byte_p0[AW-1:0];
                    end else begin
                        err_p0 = 1'b1;
                    end
                end
                BCNT: begin
                    if (len_ok_p0) begin
                        bcnt_p0 = byte_p0[CW-1:0];
                    end else begin
                        err_p0 = 1'b1;
                    end
                end
                BDATA: begin
                    wr_en_p0 = 1'b1;
                    addr_p0  = baddr_p1;
                    data_p0  = byte_p0;
                    baddr_p0 = wrap_inc(baddr_p1);
                    bcnt_p0  = bcnt_p1 - 1'b1;
                end
                OPA: begin
                    wr_en_p0 = 1'b1;
                    addr_p0  = AW'(OPA_ADDR);
                    data_p0  = byte_p0;
                end
                OPB: begin
                    wr_en_p0 = 1'b1;
                    addr_p0  = AW'(OPB_ADDR);
                    data_p0  = byte_p0;
                end
                FUN: begin
                    alu_en_p0 = 1'b1;
                    fun_p0    = byte_p0[FUN_W-1:0];
                end
                default: ;
            endcase
        end
    end

    // Gate stays open while waiting for the function byte and through the launch cycle.
    assign cge_p0 = (state_nxt == FUN) || alu_en_p0;

    // ---- stage p1: registered outputs ----
    always_ff @(posedge CLK) begin
        if (Reset) begin
            wr_en_p1  <= 1'b0;
            rd_en_p1  <= 1'b0;
            alu_en_p1 <= 1'b0;
            err_p1    <= 1'b0;
            cge_p1    <= 1'b0;
            addr_p1   <= '0;
            data_p1   <= '0;
            fun_p1    <= '0;
        end else begin
            wr_en_p1  <= wr_en_p0;
            rd_en_p1  <= rd_en_p0;
            alu_en_p1 <= alu_en_p0;
            err_p1    <= err_p0;
            cge_p1    <= cge_p0;
            addr_p1   <= addr_p0;
            data_p1   <= data_p0;
            fun_p1    <= fun_p0;
        end
    end

    always_ff @(posedge CLK) begin
        baddr_p1 <= baddr_p0;
        bcnt_p1  <= bcnt_p0;
    end

    assign bus.WrEN             = wr_en_p1;
    assign bus.RdEN             = rd_en_p1;
    assign bus.ALU_EN           = alu_en_p1;
    assign bus.ALU_FUN          = fun_p1;
    assign bus.Reg_File_Address = addr_p1;
    assign bus.WrData           = data_p1;
    assign bus.CLK_GATE_EN      = cge_p1;
    assign bus.Frame_Err        = err_p1;
    assign bus.Busy             = (state != IDLE);

endmodule

// File: tb/tb_sys_cmd_rx_ctrl.sv
// Bench for sys_cmd_rx_ctrl: directed frames plus a random byte stream, checked by a
// scoreboard fed from a frame-level reference model.
module tb_sys_cmd_rx_ctrl;
    localparam int WIDTH = 8, DEPTH = 16, AW = 4, FUN_W = 4;
    localparam int OPA = 0, OPB = 1, MAXB = 8, TMO = 20;

    localparam logic [3:0] EV_WR = 4'b0001, EV_RD = 4'b0010, EV_ALU = 4'b0100, EV_ERR = 4'b1000;

    logic CLK = 1'b0;
    logic Reset = 1'b1;
    always #5 CLK = ~CLK;

    sys_cmd_rx_ctrl_if #(.WIDTH(WIDTH), .AW(AW), .FUN_W(FUN_W)) bif ();

    sys_cmd_rx_ctrl #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .FUN_W(FUN_W), .OPA_ADDR(OPA), .OPB_ADDR(OPB),
        .MAX_BURST(MAXB), .TIMEOUT(TMO)
    ) dut (
        .CLK(CLK),
        .Reset(Reset),
        .bus(bif)
    );

    typedef struct {
        int         stamp;
        logic [3:0] kind;
        int         addr;
        int         data;
    } ev_t;

    ev_t exp_q[$];
    int  frame[$];
    int  gap = 0;
    int  cyc = 0;
    int  total = 0;
    int  bad = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [3:0] kind, input int addr, input int data);
        ev_t e;
        e.stamp = cyc + 1;
        e.kind  = kind;
        e.addr  = addr;
        e.data  = data;
        exp_q.push_back(e);
    endtask

    // Frame-level model: interpret the bytes gathered so far for the current frame.
    task automatic model_byte(input int b);
        int n;
        frame.push_back(b);
        n = frame.size();
        case (frame[0])
            'hAA: if (n == 2 && b >= DEPTH) begin push(EV_ERR, 0, 0); frame.delete(); end
                  else if (n == 3) begin push(EV_WR, frame[1], b); frame.delete(); end
            'hBB: if (n == 2) begin
                      if (b >= DEPTH) push(EV_ERR, 0, 0); else push(EV_RD, b, 0);
                      frame.delete();
                  end
            'hCC: if (n == 2) push(EV_WR, OPA, b);
                  else if (n == 3) push(EV_WR, OPB, b);
                  else if (n == 4) begin push(EV_ALU, 0, b % (1 << FUN_W)); frame.delete(); end
            'hDD: if (n == 2) begin push(EV_ALU, 0, b % (1 << FUN_W)); frame.delete(); end
            'hEE: if (n == 2 && b >= DEPTH) begin push(EV_ERR, 0, 0); frame.delete(); end
                  else if (n == 3 && (b == 0 || b > MAXB)) begin push(EV_ERR, 0, 0); frame.delete(); end
                  else if (n >= 4) begin
                      push(EV_WR, (frame[1] + n - 4) % DEPTH, b);
                      if (n - 3 == frame[2]) frame.delete();
                  end
            default: begin push(EV_ERR, 0, 0); frame.delete(); end
        endcase
    endtask

    task automatic send_byte(input int b);
        @(negedge CLK);
        bif.RxValid   = 1'b1;
        bif.Rx_P_Data = 8'(b);
        gap = 0;
        model_byte(b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            bif.RxValid   = 1'b0;
            bif.Rx_P_Data = 8'($urandom);
            if (frame.size() > 0) begin
                gap++;
                if (gap == TMO) begin
                    push(EV_ERR, 0, 0);
                    frame.delete();
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        Reset       = 1'b1;
        bif.RxValid = 1'b0;
        frame.delete();
        gap = 0;
        @(negedge CLK);
        Reset = 1'b0;
        chk("rst WrEN", bif.WrEN, 0);
        chk("rst RdEN", bif.RdEN, 0);
        chk("rst ALU_EN", bif.ALU_EN, 0);
        chk("rst ALU_FUN", bif.ALU_FUN, 0);
        chk("rst Frame_Err", bif.Frame_Err, 0);
        chk("rst CLK_GATE_EN", bif.CLK_GATE_EN, 0);
        chk("rst Busy", bif.Busy, 0);
        chk("rst Reg_File_Address", bif.Reg_File_Address, 0);
        chk("rst WrData", bif.WrData, 0);
    endtask

    function automatic int rgap();
        int r;
        r = $urandom_range(0, 99);
        if (r < 80) return 0;
        if (r < 90) return $urandom_range(1, 3);
        if (r < 95) return TMO - 1;
        return TMO;
    endfunction

    // Monitor: every strobe cycle must match the oldest expected event, stamped to the cycle.
    initial begin
        logic [3:0] k;
        ev_t        e;
        forever begin
            @(negedge CLK);
            k = {bif.Frame_Err, bif.ALU_EN, bif.RdEN, bif.WrEN};
            while (exp_q.size() > 0 && exp_q[0].stamp < cyc) begin
                e = exp_q.pop_front();
                chk("missing strobe", 32'(cyc), 32'(e.stamp));
            end
            if (k != 4'b0 || (exp_q.size() > 0 && exp_q[0].stamp == cyc)) begin
                if (exp_q.size() == 0 || exp_q[0].stamp != cyc) begin
                    chk("unexpected strobe", k, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe kind", k, e.kind);
                    if (e.kind == EV_WR) begin
                        chk("wr addr", bif.Reg_File_Address, e.addr);
                        chk("wr data", bif.WrData, e.data);
                    end else if (e.kind == EV_RD) begin
                        chk("rd addr", bif.Reg_File_Address, e.addr);
                    end else if (e.kind == EV_ALU) begin
                        chk("alu fun", bif.ALU_FUN, e.data);
                        chk("gate during alu", bif.CLK_GATE_EN, 1);
                    end
                end
            end
        end
    end

    initial begin
        int bytes[$];
        int len;
        int nb;
        bif.RxValid   = 1'b0;
        bif.Rx_P_Data = '0;
        repeat (2) @(negedge CLK);
        do_reset();

        // write then read
        send_byte('hAA); send_byte('h05); send_byte('h3C);
        send_byte('hBB); send_byte('h05);
        idle(2);

        // ALU with operands, clock gate around FUN
        send_byte('hCC); send_byte('h12); send_byte('h34);
        idle(1);
        chk("gate in FUN", bif.CLK_GATE_EN, 1);
        chk("busy in FUN", bif.Busy, 1);
        send_byte('h03);
        idle(1);
        chk("busy after alu", bif.Busy, 0);
        idle(1);
        chk("gate after alu", bif.CLK_GATE_EN, 0);
        send_byte('hDD); send_byte('h07);
        idle(2);

        // burst with wrap, then zero-length burst
        send_byte('hEE); send_byte('h0E); send_byte('h03);
        send_byte('hA1); send_byte('hA2); send_byte('hA3);
        send_byte('hEE); send_byte('h00); send_byte('h00);
        idle(1);
        chk("busy after bad burst", bif.Busy, 0);

        // range and opcode errors
        send_byte('hAA); send_byte('h10);
        idle(1);
        chk("busy after range err", bif.Busy, 0);
        send_byte('h55);
        idle(1);
        chk("busy after stray", bif.Busy, 0);

        // timeout, recovery, and byte exactly on the expiry cycle
        send_byte('hAA); send_byte('h03);
        idle(TMO);
        idle(1);
        chk("busy after timeout", bif.Busy, 0);
        send_byte('hAA); send_byte('h03); send_byte('hFF);
        send_byte('hAA); send_byte('h03);
        idle(TMO - 1);
        chk("busy before expiry", bif.Busy, 1);
        send_byte('h5A);
        idle(2);

        // reset mid-frame
        send_byte('hCC); send_byte('h11);
        do_reset();
        send_byte('hBB); send_byte('h02);
        idle(2);

        // random frames, some truncated, with occasional resets and long gaps
        for (int f = 0; f < 200; f++) begin
            bytes.delete();
            if ($urandom_range(0, 39) == 0) do_reset();
            case ($urandom_range(0, 6))
                0: begin bytes.push_back('hAA); bytes.push_back($urandom_range(0, 19));
                         bytes.push_back($urandom_range(0, 255)); end
                1: begin bytes.push_back('hBB); bytes.push_back($urandom_range(0, 19)); end
                2: begin bytes.push_back('hCC); bytes.push_back($urandom_range(0, 255));
                         bytes.push_back($urandom_range(0, 255));
                         bytes.push_back($urandom_range(0, 255)); end
                3: begin bytes.push_back('hDD); bytes.push_back($urandom_range(0, 255)); end
                4, 5: begin
                    nb = $urandom_range(0, 10);
                    bytes.push_back('hEE); bytes.push_back($urandom_range(0, 19));
                    bytes.push_back(nb);
                    for (int i = 0; i < nb; i++) bytes.push_back($urandom_range(0, 255));
                end
                default: bytes.push_back($urandom_range(0, 255));
            endcase
            len = bytes.size();
            if ($urandom_range(0, 9) == 0) len = $urandom_range(1, bytes.size());
            for (int i = 0; i < len; i++) begin
                if (i > 0) idle(rgap());
                send_byte(bytes[i]);
            end
            idle($urandom_range(0, 2));
        end

        idle(TMO + 5);
        chk("scoreboard drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sys_cmd_rx_ctrl.md
Name: sys_cmd_rx_ctrl

Overview:
Parametrised second-generation receive-side system controller. It sits between the UART receiver's parallel output and the register file, ALU and clock gate. It decodes byte-framed commands into register-file write/read strobes and ALU launches. Beyond the first generation, it adds burst writes, address range checking, an inter-byte timeout and an error/busy status.

Parameters:
WIDTH, 8, data/byte width; must be >= 8 so that opcodes fit.
DEPTH, 16, register-file depth; AW = $clog2(DEPTH).
FUN_W, 4, ALU function code width; taken from the FUN_W LSBs of the function byte.
OPA_ADDR, 0, register-file address for operand A.
OPB_ADDR, 1, register-file address for operand B.
MAX_BURST, 8, maximum burst-write length in bytes.
TIMEOUT, 1024, idle cycles allowed between bytes of one frame; 0 disables the timeout.

Ports:
CLK  in  1  system clock
Reset  in  1  synchronous, active-high reset
Rx_P_Data  in  WIDTH  received byte
RxValid  in  1  one-cycle strobe; Rx_P_Data is valid this cycle
ALU_EN  out  1  one-cycle ALU launch pulse
ALU_FUN  out  FUN_W  ALU function; held until the next ALU command
Reg_File_Address  out  AW  register-file address
WrEN  out  1  one-cycle register-file write pulse
RdEN  out  1  one-cycle register-file read pulse
WrData  out  WIDTH  write data, valid while WrEN=1
CLK_GATE_EN  out  1  ALU clock-gate enable
Frame_Err  out  1  one-cycle error pulse
Busy  out  1  high while a frame is in progress (state != IDLE)

Behaviour:
- One clock, CLK. Reset is synchronous and active-high.
- Reset state: all outputs are 0 and the FSM is in IDLE. A Reset asserted mid-frame aborts the frame with no write, read or ALU pulse issued afterwards.
- All outputs are registered. A byte accepted on edge N produces its response strobes in cycle N+1, with address and data aligned to the strobe.
- Opcodes are recognised in IDLE only: 0xAA write, 0xBB read, 0xCC ALU with operands, 0xDD ALU without operands, 0xEE burst write. Any other byte in IDLE pulses Frame_Err and the FSM stays in IDLE.
- FSM states: IDLE, WADDR, WDATA, RADDR, BADDR, BCNT, BDATA, OPA, OPB, FUN.
- Write frame (AA, addr, data): IDLE->WADDR->WDATA->IDLE. On the data byte: WrEN=1, Reg_File_Address=addr, WrData=data.
- Read frame (BB, addr): IDLE->RADDR->IDLE. On the address byte: RdEN=1, Reg_File_Address=addr.
- Address check (WADDR, RADDR, BADDR): if the address byte >= DEPTH, Frame_Err pulses, no strobe is issued and the FSM returns to IDLE.
- Burst frame (EE, addr, N, d0..dN-1): IDLE->BADDR->BCNT->BDATA->IDLE.
  - N=0 or N>MAX_BURST: Frame_Err pulses, FSM returns to IDLE.
  - Each data byte issues a WrEN pulse to the current address. The address then increments modulo DEPTH, wrapping DEPTH-1 -> 0.
  - The FSM leaves BDATA after the N-th byte.
- ALU-with-operands frame (CC, A, B, fun): IDLE->OPA->OPB->FUN->IDLE.
  - Byte A writes to OPA_ADDR; byte B writes to OPB_ADDR, each with a WrEN pulse.
  - The fun byte produces ALU_EN=1 and ALU_FUN=fun[FUN_W-1:0].
- ALU-without-operands frame (DD, fun): IDLE->FUN->IDLE.
- CLK_GATE_EN: rises the cycle after the FSM enters FUN. It stays high while in FUN and through the ALU_EN cycle, then falls the following cycle.
- Reg_File_Address holds its last value when no strobe is active.
- WrEN and RdEN are never both 1 in the same cycle. At most one strobe of each type is issued per accepted byte.
- Timeout (TIMEOUT > 0):
  - The counter clears on every RxValid and in IDLE; it counts in every other state.
  - When the count reaches TIMEOUT: Frame_Err pulses, the FSM returns to IDLE and any partial burst is abandoned. Bytes already written stay written.
  - If RxValid arrives in the same cycle the count reaches TIMEOUT, RxValid wins: the byte is accepted and no error is raised.
- A new opcode is accepted in the cycle immediately after a frame completes (back-to-back frames, no gap required).
- Busy = (state != IDLE). Busy is deasserted in the cycle after the last byte of a frame.

Test Plan:
- Write then read: AA,05,3C then BB,05 -> WrEN@addr5 with data 0x3C, then RdEN@addr5; Frame_Err stays 0.
- ALU frame: CC,12,34,03 -> WrEN addr0 data 0x12; WrEN addr1 data 0x34; ALU_EN pulse with ALU_FUN=3. CLK_GATE_EN high from FUN entry through the ALU_EN cycle. Follow with DD,07 -> ALU_EN with ALU_FUN=7.
- Burst wrap: EE,0E,03,A1,A2,A3 -> writes A1@14, A2@15, A3@0. Then EE,00,00 -> Frame_Err pulse and FSM in IDLE.
- Range/opcode errors: AA,10 (DEPTH=16) -> Frame_Err, no WrEN. A stray byte 0x55 in IDLE -> Frame_Err, Busy stays 0.
- Timeout with TIMEOUT=20: AA,03 followed by 20 idle cycles -> Frame_Err, Busy falls. A later AA,03,FF writes 0xFF@3. RxValid on exactly cycle 20 -> accepted, no error.
- Reset mid-frame: CC,11, then Reset for 1 cycle -> all outputs 0 and no ALU_EN. A subsequent BB,02 -> RdEN@2.
